queue_enq_arbiter: RTL and testbench



---
 rtl/queue_enq_arbiter_pkg.sv | 45 ++++
 rtl/queue_enq_arbiter_rr_pick.sv | 28 ++
 rtl/queue_enq_arbiter.sv | 143 ++++++++++++++
 tb/tb_queue_enq_arbiter.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/queue_enq_arbiter_pkg.sv
// Shared types and helpers for the queue enqueue arbiter.
//   arb_state_t    : arbiter FSM encoding (IDLE / LOCKED)
//   DEF_*          : default parameter values for the top level
//   pick_t         : result of a rotating first-set search (found flag + index)
//   rot_first_set  : first set bit of vec[n-1:0], searching start, start+1, ... mod n
package queue_enq_arbiter_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  localparam int unsigned DEF_NUM_REQ   = 4;
  localparam int unsigned DEF_WIDTH     = 32;
  localparam int unsigned DEF_MAX_BURST = 4;

  // The search helper works on a fixed-size vector; callers zero-extend.
  localparam int unsigned PICK_MAX = 32;
  localparam int unsigned PICK_IDW = 5;

  typedef struct packed {
    logic                found;
    logic [PICK_IDW-1:0] idx;
  } pick_t;

  function automatic pick_t rot_first_set(input logic [PICK_MAX-1:0] vec,
                                          input logic [PICK_IDW-1:0] start,
                                          input int unsigned         n);
    pick_t       res;
    int unsigned j;
    res = '0;
    j   = 0;
    for (int unsigned k = 0; k < PICK_MAX; k++) begin
      if ((k < n) && !res.found) begin
        j = (32'(start) + k) % n;
        if (vec[j[PICK_IDW-1:0]]) begin
          res.found = 1'b1;
          res.idx   = PICK_IDW'(j);
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/queue_enq_arbiter_rr_pick.sv
// rr_pick: combinational rotating-priority encoder.
// Returns the first asserted bit of valid_i, searching from start_i upward
// with wrap-around. Reusable for any round-robin arbiter (N <= 32).
//   valid_i [N-1:0]   request vector
//   start_i [IDW-1:0] highest-priority position
//   idx_o   [IDW-1:0] selected index (0 when nothing is found)
//   found_o           at least one request bit is set
module rr_pick
  import queue_enq_arbiter_pkg::*;
#(
  parameter int unsigned N   = DEF_NUM_REQ,
  parameter int unsigned IDW = $clog2(N)
) (
  input  logic [N-1:0]   valid_i,
  input  logic [IDW-1:0] start_i,
  output logic [IDW-1:0] idx_o,
  output logic           found_o
);

  pick_t pick;

  always_comb begin
    pick    = rot_first_set(PICK_MAX'(valid_i), PICK_IDW'(start_i), N);
    idx_o   = IDW'(pick.idx);
    found_o = pick.found;
  end

endmodule

// File: rtl/queue_enq_arbiter.sv
// queue_enq_arbiter: round-robin arbiter sharing one circular-queue enqueue
// port among NUM_REQ producers, with bounded bursts of up to MAX_BURST beats
// so multi-beat groups land contiguously in the queue.
//   clk, rst       clock, synchronous active-high reset
//   flush          aborts any burst; no transfer in that cycle
//   req_valid      per-requester beat valid
//   req_last       beat closes the requester's group
//   req_data       packed beats, requester i at [i*WIDTH +: WIDTH]
//   req_ready      one-hot (or zero) combinational grant
//   q_space_avail  queue not full
//   q_enq_en       enqueue strobe
//   q_din          enqueue data (zero when no transfer)
module queue_enq_arbiter
  import queue_enq_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ   = DEF_NUM_REQ,
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned MAX_BURST = DEF_MAX_BURST
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0]       req_last,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     q_space_avail,
  output logic                     q_enq_en,
  output logic [WIDTH-1:0]         q_din
);

  localparam int unsigned      IDW      = $clog2(NUM_REQ);
  localparam int unsigned      CW       = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [IDW-1:0]   LAST_IDX = IDW'(NUM_REQ - 1);
  localparam logic [CW-1:0]    CNT_MAX  = CW'(MAX_BURST - 1);

  arb_state_t     state_q, state_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]  beat_cnt_q, beat_cnt_d;

  logic [IDW-1:0] pick_idx;
  logic           pick_found;
  logic [IDW-1:0] cand;
  logic [IDW-1:0] cand_nxt;
  logic           cand_valid;
  logic           xfer;
  logic           burst_end;

  rr_pick #(
    .N   (NUM_REQ),
    .IDW (IDW)
  ) u_pick (
    .valid_i (req_valid),
    .start_i (rr_ptr_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  // Grant path: purely combinational so a beat is accepted in the cycle it is offered.
  always_comb begin
    cand       = (state_q == LOCKED) ? owner_q : pick_idx;
    cand_valid = (state_q == LOCKED) ? req_valid[owner_q] : pick_found;
    xfer       = q_space_avail & cand_valid & ~flush & ~rst;
    req_ready  = '0;
    if (xfer) begin
      req_ready[cand] = 1'b1;
    end
    q_enq_en  = xfer;
    q_din     = xfer ? req_data[32'(cand)*WIDTH +: WIDTH] : '0;
    burst_end = req_last[cand] | (beat_cnt_q == CNT_MAX);
    cand_nxt  = (cand == LAST_IDX) ? '0 : cand + 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    if (flush) begin
      state_d    = IDLE;
      beat_cnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (xfer) begin
            if (burst_end) begin
              rr_ptr_d   = cand_nxt;
              beat_cnt_d = '0;
            end else begin
              state_d    = LOCKED;
              owner_d    = cand;
              beat_cnt_d = CW'(1);
            end
          end
        end
        LOCKED: begin
          // In LOCKED cand == owner_q, so cand_nxt is owner+1.
          if (!req_valid[owner_q]) begin
            state_d    = IDLE;
            rr_ptr_d   = cand_nxt;
            beat_cnt_d = '0;
          end else if (xfer) begin
            if (burst_end) begin
              state_d    = IDLE;
              rr_ptr_d   = cand_nxt;
              beat_cnt_d = '0;
            end else begin
              beat_cnt_d = beat_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_d    = IDLE;
          beat_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ($onehot0(req_ready));
      assert (!q_enq_en || q_space_avail);
      assert ((state_q != LOCKED) || (beat_cnt_q != '0));
    end
  end

endmodule

// File: tb/tb_queue_enq_arbiter.sv
// Directed bench for queue_enq_arbiter (NUM_REQ=4, WIDTH=32, MAX_BURST=4).
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_queue_enq_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned W  = 32;
  localparam int unsigned MB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic [NR-1:0] req_valid;
  logic [NR-1:0] req_last;
  logic [NR*W-1:0] req_data;
  logic [NR-1:0] req_ready;
  logic          q_space_avail;
  logic          q_enq_en;
  logic [W-1:0]  q_din;

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;
  logic [W-1:0] dat [NR];

  always #5 clk = ~clk;

  queue_enq_arbiter #(
    .NUM_REQ   (NR),
    .WIDTH     (W),
    .MAX_BURST (MB)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .req_valid     (req_valid),
    .req_last      (req_last),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .q_space_avail (q_space_avail),
    .q_enq_en      (q_enq_en),
    .q_din         (q_din)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs and check the grant; g<0 means no transfer expected.
  task automatic step(input string tag, input logic [NR-1:0] v, input logic [NR-1:0] l,
                      input logic sp, input logic fl, input logic r, input int g);
    logic [NR-1:0] er;
    @(negedge clk);
    req_valid     = v;
    req_last      = l;
    q_space_avail = sp;
    flush         = fl;
    rst           = r;
    #1;
    er = (g < 0) ? '0 : (NR'(1) << g);
    chk({tag, ".ready"}, W'(req_ready), W'(er));
    chk({tag, ".enq"},   W'(q_enq_en),  W'(g >= 0));
    chk({tag, ".din"},   q_din,         (g < 0) ? '0 : dat[g]);
  endtask

  initial begin
    rst           = 1'b1;
    flush         = 1'b0;
    req_valid     = '0;
    req_last      = '0;
    q_space_avail = 1'b0;
    for (int i = 0; i < NR; i++) begin
      dat[i] = 32'hA0A0_0000 + 32'(i) * 32'h1111_0101;
      req_data[i*W +: W] = dat[i];
    end

    // Reset: no grant even with everything valid and space available.
    step("rst_a", 4'b1111, 4'b1111, 1'b1, 1'b0, 1'b1, -1);
    step("rst_b", 4'b1111, 4'b1111, 1'b1, 1'b0, 1'b1, -1);

    // Single-beat groups rotate 0,1,2,3,0.
    step("rr0", 4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0, 0);
    step("rr1", 4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0, 1);
    step("rr2", 4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0, 2);
    step("rr3", 4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0, 3);
    step("rr4", 4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0, 0);

    // Requester 1 alone moves the pointer to 2; then requester 2 sends 3 beats.
    step("mv1",  4'b0010, 4'b1111, 1'b1, 1'b0, 1'b0, 1);
    step("b3_1", 4'b0111, 4'b0011, 1'b1, 1'b0, 1'b0, 2);
    step("b3_2", 4'b0111, 4'b0011, 1'b1, 1'b0, 1'b0, 2);
    step("b3_3", 4'b0111, 4'b0111, 1'b1, 1'b0, 1'b0, 2);
    step("b3_n", 4'b0011, 4'b1111, 1'b1, 1'b0, 1'b0, 0);

    // Requester 1 without req_last: cut after 4 beats, 2 and 0 served, then 1 resumes.
    step("cap1", 4'b0111, 4'b0101, 1'b1, 1'b0, 1'b0, 1);
    step("cap2", 4'b0111, 4'b0101, 1'b1, 1'b0, 1'b0, 1);
    step("cap3", 4'b0111, 4'b0101, 1'b1, 1'b0, 1'b0, 1);
    step("cap4", 4'b0111, 4'b0101, 1'b1, 1'b0, 1'b0, 1);
    step("capo2", 4'b0111, 4'b0101, 1'b1, 1'b0, 1'b0, 2);
    step("capo0", 4'b0111, 4'b0101, 1'b1, 1'b0, 1'b0, 0);
    step("cap5", 4'b0111, 4'b0101, 1'b1, 1'b0, 1'b0, 1);
    step("cap6", 4'b0111, 4'b0101, 1'b1, 1'b0, 1'b0, 1);
    step("caprel", 4'b0101, 4'b0101, 1'b1, 1'b0, 1'b0, -1);
    step("capnx", 4'b0101, 4'b0101, 1'b1, 1'b0, 1'b0, 2);
    step("idle1", 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, -1);

    // Requester 3 burst stalls at beat_cnt=2 for 3 cycles, then finishes 4 beats.
    step("st_b1", 4'b1000, 4'b0000, 1'b1, 1'b0, 1'b0, 3);
    step("st_b2", 4'b1000, 4'b0000, 1'b1, 1'b0, 1'b0, 3);
    step("st_s1", 4'b1001, 4'b0001, 1'b0, 1'b0, 1'b0, -1);
    step("st_s2", 4'b1001, 4'b0001, 1'b0, 1'b0, 1'b0, -1);
    step("st_s3", 4'b1001, 4'b0001, 1'b0, 1'b0, 1'b0, -1);
    step("st_b3", 4'b1001, 4'b0001, 1'b1, 1'b0, 1'b0, 3);
    step("st_b4", 4'b1001, 4'b0001, 1'b1, 1'b0, 1'b0, 3);
    step("st_nx", 4'b1001, 4'b0001, 1'b1, 1'b0, 1'b0, 0);
    step("idle2", 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, -1);

    // Owner 0 drops valid mid-burst: no transfer that cycle, then 3 is granted.
    step("dr_b1", 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0, 0);
    step("dr_rel", 4'b1000, 4'b1000, 1'b1, 1'b0, 1'b0, -1);
    step("dr_nx", 4'b1000, 4'b1000, 1'b1, 1'b0, 1'b0, 3);
    step("idle3", 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, -1);

    // Flush mid-burst keeps rr_ptr (=2); reset mid-burst returns priority to 0.
    step("fl_mv", 4'b0010, 4'b1111, 1'b1, 1'b0, 1'b0, 1);
    step("fl_b1", 4'b0100, 4'b0000, 1'b1, 1'b0, 1'b0, 2);
    step("fl_fl", 4'b0101, 4'b0000, 1'b1, 1'b1, 1'b0, -1);
    step("fl_a1", 4'b0101, 4'b0000, 1'b1, 1'b0, 1'b0, 2);
    step("fl_a2", 4'b0101, 4'b0000, 1'b1, 1'b0, 1'b0, 2);
    step("fl_rst", 4'b0101, 4'b0000, 1'b1, 1'b0, 1'b1, -1);
    step("rs_a", 4'b0101, 4'b0101, 1'b1, 1'b0, 1'b0, 0);
    step("rs_b", 4'b0101, 4'b0101, 1'b1, 1'b0, 1'b0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
